// File: rtl/wfg_drive_spi_pkg.sv
// Shared types and limits for the SPI DAC drive block: FSM states, legal
// word-length range and the helper that clamps the configured length into it.
package wfg_drive_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned WLEN_MIN  = 7;
  localparam int unsigned WLEN_MAX  = 17;
  localparam int unsigned BIT_CNT_W = $clog2(WLEN_MAX + 1);

  // Word length is stored as (bits - 1); out-of-range requests snap to the limits.
  function automatic logic [BIT_CNT_W-1:0] clamp_wlen(input logic [4:0] wlen);
    logic [BIT_CNT_W-1:0] r;
    if (wlen < 5'(WLEN_MIN)) begin
      r = BIT_CNT_W'(WLEN_MIN);
    end else if (wlen > 5'(WLEN_MAX)) begin
      r = BIT_CNT_W'(WLEN_MAX);
    end else begin
      r = BIT_CNT_W'(wlen);
    end
    return r;
  endfunction

endpackage

// File: rtl/wfg_drive_spi_clkgen.sv
// SCLK divider: counts 0..clkdiv per half period while a frame runs, emits the
// half-period tick / bit-end strobes and drives the registered SCLK level.
module wfg_drive_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             shift_i,
  input  logic             cpol_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  output logic             tick_o,
  output logic             bit_end_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic             mid_bit;

  // phase_q is 1 during the first half of a SHIFT bit; SETUP consumes one
  // half period so its tick lands on phase 0 and aligns the bit halves.
  assign tick_o    = run_i & (cnt_q == clkdiv_i);
  assign mid_bit   = tick_o & phase_q;
  assign bit_end_o = tick_o & ~phase_q;
  assign sclk_o    = sclk_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      sclk_d  = cpol_i;
    end else begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (tick_o) begin
        phase_d = ~phase_q;
      end
      if (shift_i && mid_bit) begin
        sclk_d = ~cpol_i;
      end else if (bit_end_o) begin
        sclk_d = cpol_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

endmodule

// File: rtl/wfg_drive_spi_core.sv
// SPI master that shifts one truncated stimulus sample per sync pulse to a DAC.
// Define WFG_SPI_OFFSET_BIN_EN to invert the word MSB (offset-binary output).
module wfg_drive_spi_core
  import wfg_drive_spi_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_i,
  input  logic              ctrl_en_i,
  input  logic [DIV_W-1:0]  cfg_clkdiv_i,
  input  logic              cfg_cpol_i,
  input  logic              cfg_lsbfirst_i,
  input  logic [4:0]        cfg_wlen_i,
  input  logic              wfg_axis_tvalid_i,
  input  logic [DATA_W-1:0] wfg_axis_tdata_i,
  output logic              wfg_axis_tready_o,
  output logic              spi_cs_no,
  output logic              spi_sclk_o,
  output logic              spi_sdo_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output state_e            dbg_state_o
);

  localparam int SHAMT_W = $clog2(DATA_W);

  // Stream handshake: a sample transfers on a cycle where tvalid and tready are
  // both high. tready is only offered in IDLE on a sync pulse while enabled, so
  // at most one sample is accepted per sync and nothing is ever queued.
  state_e               state_q, state_d;
  logic [DATA_W-1:0]    word_q, word_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic                 lsb_q, lsb_d;
  logic [BIT_CNT_W-1:0] wlen_q, wlen_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sdo_q, sdo_d;
  logic                 done_q, done_d;

  logic                 capture;
  logic [BIT_CNT_W-1:0] wlen_new;
  logic [SHAMT_W-1:0]   shamt;
  logic [DATA_W-1:0]    word_new;
  logic [BIT_CNT_W-1:0] first_idx;
  logic [BIT_CNT_W-1:0] next_cnt;
  logic [BIT_CNT_W-1:0] next_idx;
  logic                 tick;
  logic                 bit_end;
  logic                 sclk;

  assign wfg_axis_tready_o = rst_n & ctrl_en_i & (state_q == IDLE) & sync_i;
  assign capture           = wfg_axis_tvalid_i & wfg_axis_tready_o;

  // The selected word is right-aligned so bit index equals bit weight.
  always_comb begin
    wlen_new = clamp_wlen(cfg_wlen_i);
    shamt    = SHAMT_W'(DATA_W - 1) - SHAMT_W'(wlen_new);
    word_new = wfg_axis_tdata_i >> shamt;
`ifdef WFG_SPI_OFFSET_BIN_EN
    word_new[wlen_new] = ~word_new[wlen_new];
`endif
    first_idx = cfg_lsbfirst_i ? '0 : wlen_new;
    next_cnt  = bit_cnt_q + 1'b1;
    next_idx  = lsb_q ? next_cnt : wlen_q - next_cnt;
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    lsb_d     = lsb_q;
    wlen_d    = wlen_q;
    bit_cnt_d = bit_cnt_q;
    cs_n_d    = cs_n_q;
    sdo_d     = sdo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d   = SETUP;
          word_d    = word_new;
          div_d     = cfg_clkdiv_i;
          cpol_d    = cfg_cpol_i;
          lsb_d     = cfg_lsbfirst_i;
          wlen_d    = wlen_new;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          sdo_d     = word_new[first_idx];
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bit_cnt_q == wlen_q) begin
            state_d = HOLD;
          end else begin
            bit_cnt_d = next_cnt;
            sdo_d     = word_q[next_idx];
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      lsb_q     <= 1'b0;
      wlen_q    <= '0;
      bit_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      sdo_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      lsb_q     <= lsb_d;
      wlen_q    <= wlen_d;
      bit_cnt_q <= bit_cnt_d;
      cs_n_q    <= cs_n_d;
      sdo_q     <= sdo_d;
      done_q    <= done_d;
    end
  end

  // On the capture cycle the idle level is taken from the incoming config so
  // SCLK settles to the new polarity together with the CS_n falling edge.
  wfg_drive_spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q != IDLE),
    .shift_i   (state_q == SHIFT),
    .cpol_i    (capture ? cfg_cpol_i : cpol_q),
    .clkdiv_i  (div_q),
    .tick_o    (tick),
    .bit_end_o (bit_end),
    .sclk_o    (sclk)
  );

  assign spi_cs_no    = cs_n_q;
  assign spi_sclk_o   = sclk;
  assign spi_sdo_o    = sdo_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wfg_drive_spi_core.sv
// Self-checking bench for wfg_drive_spi_core: directed vector table, random
// frames against a bit-list model, and reset / enable / sync corner sequences.
module tb_wfg_drive_spi_core;

  localparam int DATA_W = 18;
  localparam int DIV_W  = 8;
`ifdef WFG_SPI_OFFSET_BIN_EN
  localparam bit OFFSET = 1'b1;
`else
  localparam bit OFFSET = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sync = 1'b0;
  logic              ctrl_en = 1'b0;
  logic [DIV_W-1:0]  cfg_clkdiv = '0;
  logic              cfg_cpol = 1'b0;
  logic              cfg_lsb = 1'b0;
  logic [4:0]        cfg_wlen = '0;
  logic              tvalid = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic              tready;
  logic              cs_n;
  logic              sclk;
  logic              sdo;
  logic              busy;
  logic              done;
  wfg_drive_spi_pkg::state_e dbg_state;

  wfg_drive_spi_core #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sync_i            (sync),
    .ctrl_en_i         (ctrl_en),
    .cfg_clkdiv_i      (cfg_clkdiv),
    .cfg_cpol_i        (cfg_cpol),
    .cfg_lsbfirst_i    (cfg_lsb),
    .cfg_wlen_i        (cfg_wlen),
    .wfg_axis_tvalid_i (tvalid),
    .wfg_axis_tdata_i  (tdata),
    .wfg_axis_tready_o (tready),
    .spi_cs_no         (cs_n),
    .spi_sclk_o        (sclk),
    .spi_sdo_o         (sdo),
    .busy_o            (busy),
    .frame_done_o      (done),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [DATA_W-1:0] td;
    int                div;
    bit                cpol;
    bit                lsb;
    int                wlen;
    logic [DATA_W-1:0] raw_word;
    int                cs_len;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // reference model
  function automatic int bits_of(input int wlen_raw);
    if (wlen_raw < 7) return 8;
    if (wlen_raw > 17) return 18;
    return wlen_raw + 1;
  endfunction

  function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] td, input int n);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[n-1-i] = td[DATA_W-1-i];
    if (OFFSET) w[n-1] = ~w[n-1];
    return w;
  endfunction

  // driver + monitor for one complete frame, called at a negedge
  task automatic run_frame(input logic [DATA_W-1:0] td, input int div, input bit cpol,
                           input bit lsb, input int wlen, input logic [DATA_W-1:0] exp_word,
                           input int exp_cs, input bit en_drop, input string tag);
    int n, cs_len, act_run, bad_half, bad_busy, bad_hs, bad_done, bits_seen, bit_err;
    bit prev_sclk, ended;
    logic [0:0] e;
    n = bits_of(wlen);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word[lsb ? k : n-1-k]);
    cs_len = 0; act_run = 0; bad_half = 0; bad_busy = 0; bad_hs = 0; bad_done = 0;
    bits_seen = 0; bit_err = 0; ended = 0; prev_sclk = cpol;
    ctrl_en = 1'b1; cfg_clkdiv = DIV_W'(div); cfg_cpol = cpol; cfg_lsb = lsb;
    cfg_wlen = 5'(wlen); tdata = td; tvalid = 1'b1; sync = 1'b1;
    #1 check({tag, " tready"}, tready, 1);
    @(negedge clk);
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      if (cs_n === 1'b0) begin
        cs_len++;
        if (busy !== 1'b1) bad_busy++;
        if (done !== 1'b0) bad_done++;
        if (sclk != cpol) act_run++;
        else if (act_run != 0) begin
          if (act_run != div + 1) bad_half++;
          act_run = 0;
        end
        if (prev_sclk == cpol && sclk != cpol) begin
          bits_seen++;
          if (exp_q.size() == 0) bit_err++;
          else begin
            e = exp_q.pop_front();
            if (sdo !== e[0]) bit_err++;
          end
        end
        prev_sclk = sclk;
        sync = ($urandom_range(0, 3) == 0);
        tvalid = 1'($urandom_range(0, 1));
        tdata = DATA_W'($urandom);
        cfg_clkdiv = DIV_W'($urandom);
        cfg_cpol = 1'($urandom_range(0, 1));
        cfg_lsb = 1'($urandom_range(0, 1));
        cfg_wlen = 5'($urandom_range(0, 31));
        ctrl_en = !en_drop;
        #1 if (tready !== 1'b0) bad_hs++;
        @(negedge clk);
      end else begin
        ended = 1;
      end
    end
    check({tag, " frame ended"}, ended, 1);
    check({tag, " done at cs rise"}, done, 1);
    check({tag, " busy after"}, busy, 0);
    check({tag, " sclk idle"}, sclk, cpol);
    check({tag, " sdo holds last"}, sdo, exp_word[lsb ? n-1 : 0]);
    sync = 1'b0; tvalid = 1'b0;
    @(negedge clk);
    check({tag, " done single"}, done, 0);
    check({tag, " bit errors"}, bit_err, 0);
    check({tag, " bit count"}, bits_seen, n);
    check({tag, " cs low len"}, cs_len, exp_cs);
    check({tag, " half period"}, bad_half, 0);
    check({tag, " busy in frame"}, bad_busy, 0);
    check({tag, " tready in frame"}, bad_hs, 0);
    check({tag, " done in frame"}, bad_done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, rises, n, div, wlen;
    bit prev, cpol, lsb;
    logic [DATA_W-1:0] td, w;

    vecs[0] = '{18'h12345, 0, 1'b0, 1'b0, 15, 18'h048D1, 34};
    vecs[1] = '{18'h3FFFF, 3, 1'b1, 1'b1, 7,  18'h000FF, 72};
    vecs[2] = '{18'h2AAAA, 0, 1'b0, 1'b0, 31, 18'h2AAAA, 38};
    vecs[3] = '{18'h20000, 0, 1'b0, 1'b0, 17, 18'h20000, 38};
    vecs[4] = '{18'h3C000, 1, 1'b0, 1'b0, 3,  18'h000F0, 36};
    vecs[5] = '{18'h10003, 2, 1'b1, 1'b0, 16, 18'h08001, 108};
    vecs[6] = '{18'h12345, 1, 1'b0, 1'b1, 11, 18'h0048D, 52};

    // reset with traffic present
    #2 rst_n = 1'b0;
    ctrl_en = 1'b1; tvalid = 1'b1; tdata = 18'h12345;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sync = 1'(i % 2);
      #1;
      if (cs_n !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0 || tready !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || dbg_state !== wfg_drive_spi_pkg::IDLE) bad++;
    end
    check("reset outputs", bad, 0);
    check("reset cs_n", cs_n, 1);
    @(negedge clk);
    rst_n = 1'b1; sync = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tready !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no sync no frame", bad, 0);
    @(negedge clk);

    // directed table
    for (int v = 0; v < 7; v++) begin
      n = bits_of(vecs[v].wlen);
      w = vecs[v].raw_word;
      if (OFFSET) w[n-1] = ~w[n-1];
      run_frame(vecs[v].td, vecs[v].div, vecs[v].cpol, vecs[v].lsb, vecs[v].wlen,
                w, vecs[v].cs_len, 1'b0, $sformatf("vec%0d", v));
    end

    // enable dropped mid-frame: frame completes, no new capture
    run_frame(18'h15A5A, 1, 1'b0, 1'b0, 12, model_word(18'h15A5A, 13),
              2 * (2 * 13 + 2), 1'b1, "en_drop");
    ctrl_en = 1'b0; sync = 1'b1; tvalid = 1'b1;
    #1 check("en_drop tready", tready, 0);
    bad = 0;
    @(negedge clk);
    sync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cs_n !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("en_drop no capture", bad, 0);
    tvalid = 1'b0; ctrl_en = 1'b1;

    // random frames against the model
    for (int r = 0; r < 25; r++) begin
      td = DATA_W'($urandom);
      div = $urandom_range(0, 3);
      cpol = 1'($urandom_range(0, 1));
      lsb = 1'($urandom_range(0, 1));
      wlen = $urandom_range(0, 31);
      n = bits_of(wlen);
      run_frame(td, div, cpol, lsb, wlen, model_word(td, n), (div + 1) * (2 * n + 2),
                1'b0, $sformatf("rnd%0d", r));
    end

    // reset asserted during bit 9 of a clamped 18-bit frame
    cfg_clkdiv = '0; cfg_cpol = 1'b0; cfg_lsb = 1'b0; cfg_wlen = 5'd31;
    tdata = 18'h2AAAA; tvalid = 1'b1; sync = 1'b1; ctrl_en = 1'b1;
    @(negedge clk);
    sync = 1'b0; tvalid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (prev == 1'b0 && sclk == 1'b1) rises++;
      prev = sclk;
      if (rises == 9) break;
      @(negedge clk);
    end
    check("midrst reached bit 9", rises, 9);
    check("midrst cs before", cs_n, 0);
    rst_n = 1'b0;
    #1;
    check("midrst cs_n", cs_n, 1);
    check("midrst busy", busy, 0);
    check("midrst sclk", sclk, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || cs_n !== 1'b1) bad++;
    end
    check("midrst no done", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
